// File: rtl/fetch_unit.sv
// fetch_unit: walks byte-wide program memory and assembles 3-byte
// instructions (opcode, A, B) for the decode/ALU stage; handles HALT and JUMP.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   start             - begin fetching at START_ADDR (from IDLE or HALTED)
//   mem_req/mem_addr  - program memory read request, byte address = PC
//   mem_rdata/mem_ack - read data, valid while mem_ack=1
//   issue_valid/ready - handshake towards execute
//   issue_opcode/a/b  - ALU select and operands of the issued instruction
//   halted            - HALT opcode reached
//   busy              - high in every state other than IDLE and HALTED
module fetch_unit #(
    parameter logic [7:0] START_ADDR = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ack,
    output logic       issue_valid,
    input  logic       issue_ready,
    output logic [2:0] issue_opcode,
    output logic [7:0] issue_a,
    output logic [7:0] issue_b,
    output logic       halted,
    output logic       busy
);

    localparam logic [7:0] OP_HALT = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_OP,
        S_FETCH_A,
        S_FETCH_B,
        S_ISSUE,
        S_HALTED
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] op_q, op_d;
    logic [7:0] a_q, a_d;
    logic [7:0] b_q, b_d;

    logic [7:0] pc_inc;

    assign pc_inc = pc_q + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= START_ADDR;
            op_q    <= 8'h00;
            a_q     <= 8'h00;
            b_q     <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        unique case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    pc_d    = START_ADDR;
                    state_d = S_FETCH_OP;
                end
            end
            S_FETCH_OP: begin
                if (mem_ack) begin
                    op_d = mem_rdata;
                    pc_d = pc_inc;
                    // PC is left pointing past the HALT byte
                    if (mem_rdata == OP_HALT) begin
                        state_d = S_HALTED;
                    end else begin
                        state_d = S_FETCH_A;
                    end
                end
            end
            S_FETCH_A: begin
                if (mem_ack) begin
                    a_d     = mem_rdata;
                    pc_d    = pc_inc;
                    state_d = S_FETCH_B;
                end
            end
            S_FETCH_B: begin
                if (mem_ack) begin
                    b_d = mem_rdata;
                    // JUMP: B is fetched only to keep the 3-byte format,
                    // the target in A replaces the increment
                    if (op_q[7]) begin
                        pc_d    = a_q;
                        state_d = S_FETCH_OP;
                    end else begin
                        pc_d    = pc_inc;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (issue_ready) begin
                    state_d = S_FETCH_OP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs come from state and registers only; no path from ack/ready.
    assign mem_req = (state_q == S_FETCH_OP) ||
                     (state_q == S_FETCH_A)  ||
                     (state_q == S_FETCH_B);
    assign mem_addr     = pc_q;
    assign issue_valid  = (state_q == S_ISSUE);
    assign issue_opcode = op_q[2:0];
    assign issue_a      = a_q;
    assign issue_b      = b_q;
    assign halted       = (state_q == S_HALTED);
    assign busy         = (state_q != S_IDLE) && (state_q != S_HALTED);

endmodule
